// File: rtl/bit_speck_pkg.sv
// Shared constants, FSM encoding and helpers for the bit-serial masked
// Speck128/128 core.
package bit_speck_pkg;

    localparam int WORD    = 64;
    localparam int ROUNDS  = 32;
    localparam int CNT_W   = 6;
    localparam int ROR_AMT = 8;
    localparam int ROL_AMT = 3;

    typedef enum logic [1:0] {
        LOAD_IDLE = 2'd0,
        RUN       = 2'd1,
        DONE      = 2'd2
    } state_e;

    // Known-answer vector, laid out as {x, y} and {l0, k0}.
    localparam logic [127:0] KAT_PT  = 128'h6c617669757165207469206564616d20;
    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] KAT_CT  = 128'ha65d98517978326578_60fedf5c570d18;

    // Bit j of the key-schedule round constant (round index < 32, so only
    // bits 0..4 can be set).
    function automatic logic rc_bit(input logic [CNT_W-1:0] rnd,
                                    input logic [CNT_W-1:0] j);
        logic [7:0] rnd_ext;
        rnd_ext = {2'b00, rnd};
        rc_bit  = (j < 6'd5) ? rnd_ext[j[2:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/bit_speck128_128_ti2_carry_share_ti2_serial_add.sv
// Two-share bit-serial adder. The carry is held as two shares; at the first
// bit of a word the externally supplied carry shares replace the flops.
module ti2_serial_add (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    input  logic first_i,
    input  logic init_a_i,
    input  logic init_b_i,
    input  logic u_a_i,
    input  logic u_b_i,
    input  logic v_a_i,
    input  logic v_b_i,
    output logic sum_a_o,
    output logic sum_b_o
);

    logic c_a_q, c_b_q;
    logic c_a_d, c_b_d;
    logic c_a, c_b;

    // Sum shares and the cross-share carry update; each carry share only
    // mixes its own u/v share with the other operand and both carry shares.
    always_comb begin
        c_a     = first_i ? init_a_i : c_a_q;
        c_b     = first_i ? init_b_i : c_b_q;
        sum_a_o = u_a_i ^ v_a_i ^ c_a;
        sum_b_o = u_b_i ^ v_b_i ^ c_b;
        c_a_d   = (u_a_i & v_a_i) ^ (u_a_i & v_b_i) ^ (u_a_i & c_a) ^
                  (u_a_i & c_b)   ^ (v_a_i & c_a)   ^ (v_a_i & c_b);
        c_b_d   = (u_b_i & v_a_i) ^ (u_b_i & v_b_i) ^ (u_b_i & c_a) ^
                  (u_b_i & c_b)   ^ (v_b_i & c_a)   ^ (v_b_i & c_b);
    end

    // Carry share flops advance only on processed bits; the carry out of
    // bit 63 is simply overwritten by the init mux at the next bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_a_q <= 1'b0;
            c_b_q <= 1'b0;
        end else if (clr_i) begin
            c_a_q <= 1'b0;
            c_b_q <= 1'b0;
        end else if (en_i) begin
            c_a_q <= c_a_d;
            c_b_q <= c_b_d;
        end
    end

endmodule

// File: rtl/bit_speck128_128_ti2_carry_share.sv
// Bit-serial, 2-share masked Speck128/128 encryption core. Data and key are
// shifted in LSB first, 32 rounds run at one bit per cycle, and the masked
// ciphertext streams out one x bit and one y bit per share per cycle.
//
// Handshake: we has priority in every state and shifts one bit per cycle;
// Start is a run/stream enable, and with Start low all state is held.
module bit_speck128_128_ti2_carry_share
    import bit_speck_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ina,
    input  logic       data_inb,
    input  logic       k_data_ina,
    input  logic       k_data_inb,
    input  logic       carry_init_a,
    input  logic       carry_init_b,
    input  logic       we,
    input  logic       Start,
    output logic [1:0] cipher_out1,
    output logic [1:0] cipher_out2,
    output logic       rndlessthan32
);

    // Word registers; bit 0 is always the bit being consumed.
    logic [WORD-1:0] x_a_q, x_b_q, y_a_q, y_b_q;
    logic [WORD-1:0] l_a_q, l_b_q, k_a_q, k_b_q;
    // Old low bits still needed by the ROR8 tap near the end of a round.
    logic [ROR_AMT-1:0] xh_a_q, xh_b_q, lh_a_q, lh_b_q;
    // Old bits j-1..j-3 needed by the ROL3 tap.
    logic [ROL_AMT-1:0] yh_a_q, yh_b_q, kh_a_q, kh_b_q;

    logic [CNT_W-1:0] bit_q, round_q;
    state_e           state_q;

    logic run_en, stream_en, first, last;
    logic hist_tap, old_tap, hist_shift, rc;
    logic rx_a, rx_b, rl_a, rl_b;
    logic ry_a, ry_b, rk_a, rk_b;
    logic xs_a, xs_b, ls_a, ls_b;
    logic xn_a, xn_b, yn_a, yn_b;
    logic ln_a, ln_b, kn_a, kn_b;

    // Control decode and rotation taps for the current bit position.
    always_comb begin
        run_en     = !we && Start && (state_q != DONE) && (round_q < CNT_W'(ROUNDS));
        stream_en  = !we && Start && (state_q == DONE);
        first      = (bit_q == '0);
        last       = (bit_q == CNT_W'(WORD - 1));
        hist_tap   = (bit_q >= CNT_W'(WORD - ROR_AMT));
        old_tap    = (bit_q < CNT_W'(ROL_AMT));
        hist_shift = (bit_q < CNT_W'(ROR_AMT)) || hist_tap;
        rc         = rc_bit(round_q, bit_q);
        rx_a       = hist_tap ? xh_a_q[0] : x_a_q[ROR_AMT];
        rx_b       = hist_tap ? xh_b_q[0] : x_b_q[ROR_AMT];
        rl_a       = hist_tap ? lh_a_q[0] : l_a_q[ROR_AMT];
        rl_b       = hist_tap ? lh_b_q[0] : l_b_q[ROR_AMT];
        ry_a       = old_tap ? y_a_q[WORD-ROL_AMT] : yh_a_q[ROL_AMT-1];
        ry_b       = old_tap ? y_b_q[WORD-ROL_AMT] : yh_b_q[ROL_AMT-1];
        rk_a       = old_tap ? k_a_q[WORD-ROL_AMT] : kh_a_q[ROL_AMT-1];
        rk_b       = old_tap ? k_b_q[WORD-ROL_AMT] : kh_b_q[ROL_AMT-1];
        // Round key k_r is applied share-wise; the round constant goes to share a only.
        xn_a       = xs_a ^ k_a_q[0];
        xn_b       = xs_b ^ k_b_q[0];
        yn_a       = ry_a ^ xn_a;
        yn_b       = ry_b ^ xn_b;
        ln_a       = ls_a ^ rc;
        ln_b       = ls_b;
        kn_a       = rk_a ^ ln_a;
        kn_b       = rk_b ^ ln_b;
    end

    ti2_serial_add u_data_add (
        .clk      (clk),
        .rst      (rst),
        .en_i     (run_en),
        .clr_i    (we),
        .first_i  (first),
        .init_a_i (carry_init_a),
        .init_b_i (carry_init_b),
        .u_a_i    (rx_a),
        .u_b_i    (rx_b),
        .v_a_i    (y_a_q[0]),
        .v_b_i    (y_b_q[0]),
        .sum_a_o  (xs_a),
        .sum_b_o  (xs_b)
    );

    ti2_serial_add u_key_add (
        .clk      (clk),
        .rst      (rst),
        .en_i     (run_en),
        .clr_i    (we),
        .first_i  (first),
        .init_a_i (carry_init_a),
        .init_b_i (carry_init_b),
        .u_a_i    (rl_a),
        .u_b_i    (rl_b),
        .v_a_i    (k_a_q[0]),
        .v_b_i    (k_b_q[0]),
        .sum_a_o  (ls_a),
        .sum_b_o  (ls_b)
    );

    // Controller: state, bit counter and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_IDLE;
            bit_q   <= '0;
            round_q <= '0;
        end else if (we) begin
            state_q <= LOAD_IDLE;
            bit_q   <= '0;
            round_q <= '0;
        end else if (run_en) begin
            state_q <= RUN;
            bit_q   <= bit_q + 1'b1;
            if (last) begin
                round_q <= round_q + 1'b1;
                if (round_q == CNT_W'(ROUNDS - 1)) begin
                    state_q <= DONE;
                end
            end
        end
    end

    // Datapath shift registers: serial load, round processing, output rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_a_q  <= '0;
            x_b_q  <= '0;
            y_a_q  <= '0;
            y_b_q  <= '0;
            l_a_q  <= '0;
            l_b_q  <= '0;
            k_a_q  <= '0;
            k_b_q  <= '0;
            xh_a_q <= '0;
            xh_b_q <= '0;
            lh_a_q <= '0;
            lh_b_q <= '0;
            yh_a_q <= '0;
            yh_b_q <= '0;
            kh_a_q <= '0;
            kh_b_q <= '0;
        end else if (we) begin
            // {x,y} and {l,k} behave as single 128-bit registers during load.
            x_a_q  <= {data_ina, x_a_q[WORD-1:1]};
            x_b_q  <= {data_inb, x_b_q[WORD-1:1]};
            y_a_q  <= {x_a_q[0], y_a_q[WORD-1:1]};
            y_b_q  <= {x_b_q[0], y_b_q[WORD-1:1]};
            l_a_q  <= {k_data_ina, l_a_q[WORD-1:1]};
            l_b_q  <= {k_data_inb, l_b_q[WORD-1:1]};
            k_a_q  <= {l_a_q[0], k_a_q[WORD-1:1]};
            k_b_q  <= {l_b_q[0], k_b_q[WORD-1:1]};
            xh_a_q <= '0;
            xh_b_q <= '0;
            lh_a_q <= '0;
            lh_b_q <= '0;
            yh_a_q <= '0;
            yh_b_q <= '0;
            kh_a_q <= '0;
            kh_b_q <= '0;
        end else if (run_en) begin
            x_a_q  <= {xn_a, x_a_q[WORD-1:1]};
            x_b_q  <= {xn_b, x_b_q[WORD-1:1]};
            y_a_q  <= {yn_a, y_a_q[WORD-1:1]};
            y_b_q  <= {yn_b, y_b_q[WORD-1:1]};
            l_a_q  <= {ln_a, l_a_q[WORD-1:1]};
            l_b_q  <= {ln_b, l_b_q[WORD-1:1]};
            k_a_q  <= {kn_a, k_a_q[WORD-1:1]};
            k_b_q  <= {kn_b, k_b_q[WORD-1:1]};
            // Capture old bits 0..7 early in the round, replay them at bits 56..63.
            if (hist_shift) begin
                xh_a_q <= {x_a_q[0], xh_a_q[ROR_AMT-1:1]};
                xh_b_q <= {x_b_q[0], xh_b_q[ROR_AMT-1:1]};
                lh_a_q <= {l_a_q[0], lh_a_q[ROR_AMT-1:1]};
                lh_b_q <= {l_b_q[0], lh_b_q[ROR_AMT-1:1]};
            end
            yh_a_q <= {yh_a_q[ROL_AMT-2:0], y_a_q[0]};
            yh_b_q <= {yh_b_q[ROL_AMT-2:0], y_b_q[0]};
            kh_a_q <= {kh_a_q[ROL_AMT-2:0], k_a_q[0]};
            kh_b_q <= {kh_b_q[ROL_AMT-2:0], k_b_q[0]};
        end else if (stream_en) begin
            x_a_q <= {x_a_q[0], x_a_q[WORD-1:1]};
            x_b_q <= {x_b_q[0], x_b_q[WORD-1:1]};
            y_a_q <= {y_a_q[0], y_a_q[WORD-1:1]};
            y_b_q <= {y_b_q[0], y_b_q[WORD-1:1]};
        end
    end

    // Outputs: ciphertext bits only in DONE, round-count flag from the counter.
    always_comb begin
        cipher_out1   = (state_q == DONE) ? {x_a_q[0], y_a_q[0]} : 2'b00;
        cipher_out2   = (state_q == DONE) ? {x_b_q[0], y_b_q[0]} : 2'b00;
        rndlessthan32 = (round_q < CNT_W'(ROUNDS));
    end

endmodule

// File: tb/tb_bit_speck128_128_ti2_carry_share.sv
// Directed bench for the bit-serial masked Speck128/128 core.
module tb_bit_speck128_128_ti2_carry_share;

    localparam logic [127:0] PT     = 128'h6c617669757165207469206564616d20;
    localparam logic [127:0] KEY    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [63:0]  CT_X   = 64'ha65d985179783265;
    localparam logic [63:0]  CT_Y   = 64'h7860fedf5c570d18;
    localparam logic [127:0] MASK_D = 128'h3c5a96e10f7b2d48a1c3e5975b2d4f86;
    localparam logic [127:0] MASK_K = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ina, data_inb, k_data_ina, k_data_inb;
    logic       carry_init_a, carry_init_b;
    logic       we, Start;
    logic [1:0] cipher_out1, cipher_out2;
    logic       rndlessthan32;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] cap_xa, cap_xb, cap_ya, cap_yb;
    logic [63:0] ref_xa;

    always #5 clk = ~clk;

    bit_speck128_128_ti2_carry_share dut (
        .clk           (clk),
        .rst           (rst),
        .data_ina      (data_ina),
        .data_inb      (data_inb),
        .k_data_ina    (k_data_ina),
        .k_data_inb    (k_data_inb),
        .carry_init_a  (carry_init_a),
        .carry_init_b  (carry_init_b),
        .we            (we),
        .Start         (Start),
        .cipher_out1   (cipher_out1),
        .cipher_out2   (cipher_out2),
        .rndlessthan32 (rndlessthan32)
    );

    // Shift a 128-bit block and key in, LSB first, one bit per cycle.
    task automatic load_block(input logic [127:0] pa, input logic [127:0] pb,
                              input logic [127:0] ka, input logic [127:0] kb);
        for (int i = 0; i < 128; i++) begin
            we = 1'b1; data_ina = pa[i]; data_inb = pb[i];
            k_data_ina = ka[i]; k_data_inb = kb[i];
            @(negedge clk);
        end
        we = 1'b0; data_ina = 1'b0; data_inb = 1'b0;
        k_data_ina = 1'b0; k_data_inb = 1'b0;
        Start = 1'b0;
    endtask

    // Collect 64 streamed bits per share; optionally hold Start low before bit hold_at.
    task automatic capture(input int hold_at, input int hold_len);
        for (int i = 0; i < 64; i++) begin
            if (i == hold_at) begin
                Start = 1'b0;
                repeat (hold_len) @(negedge clk);
            end
            cap_xa[i] = cipher_out1[1]; cap_ya[i] = cipher_out1[0];
            cap_xb[i] = cipher_out2[1]; cap_yb[i] = cipher_out2[0];
            Start = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b1) $display("FAIL reset_rnd: got %b expected 1", rndlessthan32);
        else n_pass++;
        n_total++;
        if ({cipher_out1, cipher_out2} !== 4'b0000)
            $display("FAIL reset_out: got %b expected 0000", {cipher_out1, cipher_out2});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b1) $display("FAIL idle_rnd: got %b expected 1", rndlessthan32);
        else n_pass++;
        n_total++;
        if ({cipher_out1, cipher_out2} !== 4'b0000)
            $display("FAIL idle_out: got %b expected 0000", {cipher_out1, cipher_out2});
        else n_pass++;
    endtask

    task automatic test_kat_unmasked();
        carry_init_a = 1'b1; carry_init_b = 1'b1;
        load_block(PT, 128'h0, KEY, 128'h0);
        Start = 1'b1;
        repeat (2047) @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b1) $display("FAIL kat_rnd_2047: got %b expected 1", rndlessthan32);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b0) $display("FAIL kat_rnd_2048: got %b expected 0", rndlessthan32);
        else n_pass++;
        capture(-1, 0);
        n_total++;
        if ((cap_xa ^ cap_xb) !== CT_X) $display("FAIL kat_x: got %h expected %h", cap_xa ^ cap_xb, CT_X);
        else n_pass++;
        n_total++;
        if ((cap_ya ^ cap_yb) !== CT_Y) $display("FAIL kat_y: got %h expected %h", cap_ya ^ cap_yb, CT_Y);
        else n_pass++;
        ref_xa = cap_xa;
    endtask

    task automatic test_kat_masked();
        for (int c = 0; c < 2; c++) begin
            logic [127:0] md, mk;
            md = (c == 0) ? MASK_D : ~MASK_D;
            mk = (c == 0) ? MASK_K : {MASK_K[63:0], MASK_K[127:64]};
            carry_init_a = c[0]; carry_init_b = c[0];
            load_block(PT ^ md, md, KEY ^ mk, mk);
            Start = 1'b1;
            repeat (2048) @(negedge clk);
            n_total++;
            if (rndlessthan32 !== 1'b0) $display("FAIL masked%0d_rnd: got %b expected 0", c, rndlessthan32);
            else n_pass++;
            capture(-1, 0);
            n_total++;
            if ((cap_xa ^ cap_xb) !== CT_X) $display("FAIL masked%0d_x: got %h expected %h", c, cap_xa ^ cap_xb, CT_X);
            else n_pass++;
            n_total++;
            if ((cap_ya ^ cap_yb) !== CT_Y) $display("FAIL masked%0d_y: got %h expected %h", c, cap_ya ^ cap_yb, CT_Y);
            else n_pass++;
            n_total++;
            if (cap_xa === ref_xa) $display("FAIL masked%0d_share: got %h expected a value other than %h", c, cap_xa, ref_xa);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int highs  = 0;
        int lows   = 0;
        int budget = 0;
        carry_init_a = 1'b0; carry_init_b = 1'b0;
        load_block(PT ^ MASK_D, MASK_D, KEY ^ MASK_K, MASK_K);
        while (rndlessthan32 === 1'b1 && budget < 4000) begin
            if (lows < 100 && $urandom_range(0, 9) == 0) begin
                Start = 1'b0; lows++;
            end else begin
                Start = 1'b1; highs++;
            end
            budget++;
            @(negedge clk);
        end
        n_total++;
        if (rndlessthan32 !== 1'b0) $display("FAIL stall_done: got %b expected 0 within %0d cycles", rndlessthan32, budget);
        else n_pass++;
        n_total++;
        if (highs != 2048) $display("FAIL stall_latency: got %0d expected 2048", highs);
        else n_pass++;
        capture(20, 17);
        n_total++;
        if ({cap_xa ^ cap_xb, cap_ya ^ cap_yb} !== {CT_X, CT_Y})
            $display("FAIL stall_ct: got %h expected %h", {cap_xa ^ cap_xb, cap_ya ^ cap_yb}, {CT_X, CT_Y});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        carry_init_a = 1'b1; carry_init_b = 1'b1;
        load_block(PT ^ MASK_D, MASK_D, KEY ^ MASK_K, MASK_K);
        Start = 1'b1;
        repeat (64 * 10 + 7) @(negedge clk);
        rst = 1'b1; Start = 1'b0;
        #1;
        n_total++;
        if (rndlessthan32 !== 1'b1) $display("FAIL midrst_rnd: got %b expected 1", rndlessthan32);
        else n_pass++;
        n_total++;
        if ({cipher_out1, cipher_out2} !== 4'b0000)
            $display("FAIL midrst_out: got %b expected 0000", {cipher_out1, cipher_out2});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_block(PT, 128'h0, KEY, 128'h0);
        Start = 1'b1;
        repeat (2048) @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b0) $display("FAIL midrst_reload_rnd: got %b expected 0", rndlessthan32);
        else n_pass++;
        capture(-1, 0);
        n_total++;
        if ((cap_xa ^ cap_xb) !== CT_X) $display("FAIL midrst_x: got %h expected %h", cap_xa ^ cap_xb, CT_X);
        else n_pass++;
        n_total++;
        if ((cap_ya ^ cap_yb) !== CT_Y) $display("FAIL midrst_y: got %h expected %h", cap_ya ^ cap_yb, CT_Y);
        else n_pass++;
    endtask

    task automatic test_reload_done();
        logic [127:0] pa, pb, ka, kb;
        pb = {MASK_D[63:0], MASK_D[127:64]};
        kb = ~MASK_K;
        pa = PT ^ pb;
        ka = KEY ^ kb;
        carry_init_a = 1'b0; carry_init_b = 1'b0;
        for (int i = 0; i < 128; i++) begin
            we = 1'b1; data_ina = pa[i]; data_inb = pb[i];
            k_data_ina = ka[i]; k_data_inb = kb[i];
            @(negedge clk);
            if (i == 0) begin
                n_total++;
                if (rndlessthan32 !== 1'b1) $display("FAIL reload_rnd: got %b expected 1", rndlessthan32);
                else n_pass++;
                n_total++;
                if ({cipher_out1, cipher_out2} !== 4'b0000)
                    $display("FAIL reload_out: got %b expected 0000", {cipher_out1, cipher_out2});
                else n_pass++;
            end
        end
        we = 1'b0;
        Start = 1'b1;
        repeat (2048) @(negedge clk);
        n_total++;
        if (rndlessthan32 !== 1'b0) $display("FAIL reload_done_rnd: got %b expected 0", rndlessthan32);
        else n_pass++;
        capture(-1, 0);
        n_total++;
        if ({cap_xa ^ cap_xb, cap_ya ^ cap_yb} !== {CT_X, CT_Y})
            $display("FAIL reload_ct: got %h expected %h", {cap_xa ^ cap_xb, cap_ya ^ cap_yb}, {CT_X, CT_Y});
        else n_pass++;
    endtask

    task automatic test_stream_wrap();
        logic [255:0] w0, w1;
        capture(-1, 0);
        w0 = {cap_xa, cap_ya, cap_xb, cap_yb};
        capture(-1, 0);
        w1 = {cap_xa, cap_ya, cap_xb, cap_yb};
        n_total++;
        if (w1 !== w0) $display("FAIL wrap_repeat: got %h expected %h", w1, w0);
        else n_pass++;
        n_total++;
        if ({w0[255:192] ^ w0[127:64], w0[191:128] ^ w0[63:0]} !== {CT_X, CT_Y})
            $display("FAIL wrap_ct: got %h expected %h",
                     {w0[255:192] ^ w0[127:64], w0[191:128] ^ w0[63:0]}, {CT_X, CT_Y});
        else n_pass++;
    endtask

    task automatic test_reset_in_done();
        n_total++;
        if (rndlessthan32 !== 1'b0) $display("FAIL done_rnd_pre: got %b expected 0", rndlessthan32);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (rndlessthan32 !== 1'b1) $display("FAIL donerst_rnd: got %b expected 1", rndlessthan32);
        else n_pass++;
        n_total++;
        if ({cipher_out1, cipher_out2} !== 4'b0000)
            $display("FAIL donerst_out: got %b expected 0000", {cipher_out1, cipher_out2});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; Start = 1'b0;
        data_ina = 1'b0; data_inb = 1'b0; k_data_ina = 1'b0; k_data_inb = 1'b0;
        carry_init_a = 1'b0; carry_init_b = 1'b0;
        test_reset();
        test_kat_unmasked();
        test_kat_masked();
        test_stall();
        test_reset_mid_run();
        test_reload_done();
        test_stream_wrap();
        test_reset_in_done();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
